// File: rtl/wb_burst_ram.sv
// Wishbone B3 burst-capable single-port RAM slave: registered ack/err, classic and
// incrementing bursts (linear and wrap4/8/16), byte-select writes, synchronous read.
module wb_burst_ram #(
  parameter int unsigned dw        = 32,
  parameter int unsigned aw        = 32,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] adr_q;
  logic [IDX_W-1:0] adr_inc;
  logic [IDX_W-1:0] wrap_mask;
  logic [IDX_W-1:0] req_idx;
  logic [dw-1:0]    dat_q;
  logic             ack_q;
  logic             err_q;
  logic             req;
  logic             oor;
  logic             wr_fire;

  logic [dw-1:0] mem [MEM_WORDS];

  assign req     = wb_cyc_i & wb_stb_i;
  assign req_idx = wb_adr_i[IDX_W+1:2];
  assign oor     = (wb_adr_i >> (IDX_W + 2)) != '0;
  // A beat transfers only when the master still strobes during the ack cycle.
  assign wr_fire = ack_q & req & wb_we_i & ~rst_i;

  // Next burst word: bits inside the wrap window count, bits above it hold.
  always_comb begin
    wrap_mask = '1;
    case (wb_bte_i)
      2'b01:   wrap_mask = IDX_W'(4'h3);
      2'b10:   wrap_mask = IDX_W'(4'h7);
      2'b11:   wrap_mask = IDX_W'(4'hF);
      default: wrap_mask = '1;
    endcase
    adr_inc = (adr_q & ~wrap_mask) | ((adr_q + IDX_W'(1)) & wrap_mask);
  end

  // Byte-lane write port.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[adr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  // Control FSM; read data is fetched one cycle ahead of the ack it accompanies.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req && !ack_q && !err_q) begin
            if (oor) begin
              err_q <= 1'b1;
            end else begin
              ack_q <= 1'b1;
              adr_q <= req_idx;
              dat_q <= mem[req_idx];
              if (wb_cti_i == 3'b010) state_q <= S_BURST;
            end
          end
        end
        S_BURST: begin
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end else if (ack_q && wb_stb_i) begin
            if (wb_cti_i == 3'b111) begin
              state_q <= S_IDLE;
              ack_q   <= 1'b0;
            end else begin
              ack_q <= 1'b1;
              adr_q <= adr_inc;
              dat_q <= mem[adr_inc];
            end
          end else begin
            // Wait state: hold the pending beat and resume once stb returns.
            ack_q <= wb_stb_i;
            dat_q <= mem[adr_q];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: doc/wb_burst_ram.md
WB_BURST_RAM -- requirements
Module: wb_burst_ram

Interface
REQ-001 Parameter dw, default 32, data width; only 32 is supported.
REQ-002 Parameter aw, default 32, address width of wb_adr_i.
REQ-003 Parameter MEM_WORDS, default 1024, memory depth in 32-bit words; a power of two, at least 16.
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 wb_adr_i  in  aw  byte address; bits [1:0] ignored.
REQ-007 wb_dat_i  in  32  write data.
REQ-008 wb_sel_i  in  4  byte enables; bit n selects dat[8n+7:8n].
REQ-009 wb_we_i  in  1  1 = write.
REQ-010 wb_cyc_i  in  1  cycle valid.
REQ-011 wb_stb_i  in  1  strobe.
REQ-012 wb_cti_i  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
REQ-013 wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-014 wb_dat_o  out  32  read data.
REQ-015 wb_ack_o  out  1  beat acknowledge.
REQ-016 wb_err_o  out  1  error acknowledge, for out-of-range addresses.
REQ-017 wb_rty_o  out  1  retry; tied to 0.
REQ-018 Block is the memory slave on the mem port downstream of the Wishbone interconnect.

Function
REQ-019 Request = wb_cyc_i & wb_stb_i.
REQ-020 Word index = wb_adr_i[log2(MEM_WORDS)+1:2].
REQ-021 Out of range = any wb_adr_i bit above log2(MEM_WORDS)+1 is set.
REQ-022 FSM states are IDLE and BURST; reset enters IDLE.
REQ-023 IDLE, request sampled with ack/err low: next cycle asserts wb_ack_o (or wb_err_o if out of range); latency 1 cycle.
REQ-024 IDLE, request with cti = 010 and in range: load the burst address register and move to BURST; any other cti stays IDLE.
REQ-025 Classic, constant (001) and 111 accesses give a one-cycle ack pulse; ack never high two consecutive cycles in IDLE; next access needs a fresh sample.
REQ-026 BURST: ack every cycle while request is high; each beat advances the internal word address; wb_adr_i is ignored after the first beat.
REQ-027 Address increment:
- bte 00: +1 word, wrapping modulo MEM_WORDS.
- bte 01/10/11: low 2/3/4 bits of the word index increment modulo 4/8/16; upper bits held.
REQ-028 BURST, wb_stb_i low with wb_cyc_i high (wait state): ack low, address held, and ack resumes the cycle after stb returns.
REQ-029 BURST exits to IDLE on either:
- acked beat sampled with cti = 111: ack low next cycle.
- wb_cyc_i low: abort; ack low next cycle, no further write.
REQ-030 Read data:
- wb_dat_o is valid in every cycle wb_ack_o = 1 and equals mem[current beat address].
- Storage is synchronous-read, so the next beat address is presented to the memory one cycle ahead.
REQ-031 Write:
- Committed at the rising edge where wb_ack_o = 1 and wb_we_i = 1.
- Uses that beat's address, wb_dat_i and wb_sel_i.
- Unselected bytes are unchanged.
REQ-032 No write occurs on an err beat, and memory is unchanged.
REQ-033 wb_dat_o is don't-care when ack is low.
REQ-034 wb_ack_o and wb_err_o are never both high.
REQ-035 A burst running past the address limit wraps per REQ-027 and never raises err mid-burst; range is checked on the first beat only.

Reset
REQ-036 While rst_i is sampled high, the following are 0 on the next edge: wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o, and the burst address; FSM is in IDLE.
REQ-037 Reset mid-burst: ack drops the next cycle, the aborted beat is not written, and memory contents are preserved.
REQ-038 First request after reset deasserts is sampled normally; no extra dead cycle.

Verification
REQ-039 Classic write then read:
- Stimulus: write 0xDEADBEEF to 0x10 with sel 1111, then read 0x10.
- Response: each access acked 1 cycle after the request; read returns 0xDEADBEEF; ack is a single-cycle pulse.
REQ-040 Byte select:
- Stimulus: with 0x11223344 at 0x20, write 0xAABBCCDD with sel 0101, then read 0x20.
- Response: read returns 0x11BB33DD.
REQ-041 Wrap4 read burst:
- Stimulus: preload words 0..3 with 0..3; start at byte 0x08, cti 010, bte 01, 4 beats with the last cti 111.
- Response: acks on 4 consecutive cycles; data 2, 3, 0, 1; ack low after.
REQ-042 Linear write burst with wait state:
- Stimulus: 8 beats from 0x100; stb low for 2 cycles after beat 3.
- Response: ack low during the wait and resumes the next cycle; words 0x100..0x11C written; no skipped or duplicate beat.
REQ-043 Out of range:
- Stimulus: read at 4*MEM_WORDS.
- Response: wb_err_o pulses 1 cycle later; wb_ack_o stays 0; memory unchanged.
REQ-044 Abort and reset:
- Stimulus: drop cyc after beat 2 of a wrap8 write burst, then assert rst_i mid-burst on a second burst.
- Response: exactly 2 (resp. acked) beats written; outputs 0 the next cycle; a subsequent classic read succeeds.
